// File: rtl/mult_arbiter.sv
// mult_arbiter: four requesters share one unsigned multiplier.
// One operation is in flight at a time: IDLE (arbitrate/accept) -> CALC
// (multiply) -> RESP (hold response until downstream accepts).
// Optional feature macro: MULT_ARB_ROUNDROBIN_EN selects round-robin
// arbitration with a rotating pointer. When it is undefined, the lowest
// valid index always wins and there is no pointer register.
module mult_arbiter #(
    parameter int OPW  = 2,
    parameter int NREQ = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*OPW-1:0] req_a,
    input  logic [NREQ*OPW-1:0] req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [1:0]          resp_id,
    output logic [2*OPW-1:0]    resp_product,
    output logic                busy
);

    localparam int IDW = 2;
    localparam int PW  = 2 * OPW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [OPW-1:0]     a_q, a_d;
    logic [OPW-1:0]     b_q, b_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [IDW-1:0]     resp_id_q, resp_id_d;
    logic [PW-1:0]      product_q, product_d;
    logic               resp_valid_q, resp_valid_d;
    logic               busy_q, busy_d;
`ifdef MULT_ARB_ROUNDROBIN_EN
    logic [IDW-1:0]     ptr_q, ptr_d;
`endif

    logic [OPW-1:0]     a_arr [NREQ];
    logic [OPW-1:0]     b_arr [NREQ];
    logic               found;
    logic [IDW-1:0]     grant_id;
    logic [NREQ-1:0]    grant_vec;

    // Unpack per-requester operands from the flat buses.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*OPW +: OPW];
            assign b_arr[gi] = req_b[gi*OPW +: OPW];
        end
    endgenerate

    // Arbitration: pick the winning requester among the valid ones.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
`ifdef MULT_ARB_ROUNDROBIN_EN
        // Search upward from the pointer, wrapping 3 -> 0.
        for (int k = 0; k < NREQ; k++) begin
            logic [IDW-1:0] idx;
            idx = ptr_q + k[IDW-1:0];
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                grant_id = idx;
            end
        end
`else
        // Fixed priority: lowest index wins.
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[k]) begin
                found    = 1'b1;
                grant_id = k[IDW-1:0];
            end
        end
`endif
        grant_vec = found ? (NREQ'(1) << grant_id) : '0;
    end

    // Ready is only offered while idle; it is the one-hot grant itself.
    assign req_ready    = (state_q == IDLE) ? grant_vec : '0;
    assign resp_valid   = resp_valid_q;
    assign resp_id      = resp_id_q;
    assign resp_product = product_q;
    assign busy         = busy_q;

    // Next-state and datapath update for the three-phase operation.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        resp_id_d    = resp_id_q;
        product_d    = product_q;
        resp_valid_d = resp_valid_q;
        busy_d       = busy_q;
`ifdef MULT_ARB_ROUNDROBIN_EN
        ptr_d        = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    a_d     = a_arr[grant_id];
                    b_d     = b_arr[grant_id];
                    id_d    = grant_id;
                    state_d = CALC;
                    busy_d  = 1'b1;
`ifdef MULT_ARB_ROUNDROBIN_EN
                    ptr_d   = grant_id + 1'b1;
`endif
                end
            end
            CALC: begin
                // Widen both operands so the full product is kept.
                product_d    = PW'(a_q) * PW'(b_q);
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // State register with synchronous reset that discards any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            resp_id_q    <= '0;
            product_q    <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef MULT_ARB_ROUNDROBIN_EN
            ptr_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            resp_id_q    <= resp_id_d;
            product_q    <= product_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
`ifdef MULT_ARB_ROUNDROBIN_EN
            ptr_q        <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Testbench for mult_arbiter: directed vectors, a transaction-level model
// checked every cycle, and literal expectations for key scenarios.
module tb_mult_arbiter;

    localparam int OPW = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [7:0]   req_a;
    logic [7:0]   req_b;
    logic [3:0]   req_ready;
    logic         resp_valid;
    logic         resp_ready;
    logic [1:0]   resp_id;
    logic [3:0]   resp_product;
    logic         busy;

    mult_arbiter #(.OPW(OPW), .NREQ(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_product (resp_product),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    bit m_init = 0;
    bit m_pend = 0;
    int edge_n = 0;
    int acc_edge = 0;
    int m_in_id = 0, m_in_prod = 0;
    int m_out_id = 0, m_out_prod = 0;
    int m_ptr = 0;
    int m_g;

    function automatic int model_grant(input logic [3:0] v, input int ptr);
`ifdef MULT_ARB_ROUNDROBIN_EN
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
`else
        for (int k = 0; k < 4; k++) begin
            if (v[k]) return k;
        end
`endif
        return -1;
    endfunction

    // Advance the model at every rising edge from the inputs seen there.
    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            m_init     = 1;
            m_pend     = 0;
            m_out_id   = 0;
            m_out_prod = 0;
            m_ptr      = 0;
        end else if (m_init) begin
            if (!m_pend) begin
                m_g = model_grant(req_valid, m_ptr);
                if (m_g >= 0) begin
                    m_pend    = 1;
                    acc_edge  = edge_n;
                    m_in_id   = m_g;
                    m_in_prod = int'(req_a[m_g*OPW +: OPW]) * int'(req_b[m_g*OPW +: OPW]);
`ifdef MULT_ARB_ROUNDROBIN_EN
                    m_ptr     = (m_g + 1) % 4;
`endif
                end
            end else if (edge_n - acc_edge == 1) begin
                m_out_id   = m_in_id;
                m_out_prod = m_in_prod;
            end else if (resp_ready) begin
                m_pend = 0;
            end
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        if (m_init) begin
            logic [3:0] one;
            logic [3:0] exp_rr;
            int g;
            one    = 4'b0001;
            g      = model_grant(req_valid, m_ptr);
            exp_rr = (!m_pend && g >= 0) ? (one << g) : 4'b0000;
            check("req_ready", req_ready, exp_rr);
            check("busy", busy, m_pend);
            check("resp_valid", resp_valid, m_pend && (edge_n - acc_edge >= 1));
            check("resp_id", resp_id, m_out_id);
            check("resp_product", resp_product, m_out_prod);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_accept(output int gid);
        bit ok;
        ok  = 0;
        gid = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (|req_ready) begin
                for (int j = 0; j < 4; j++) if (req_ready[j]) gid = j;
                ok = 1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_resp(output int id, output int prod);
        bit ok;
        ok = 0;
        id = -1;
        prod = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                id   = resp_id;
                prod = resp_product;
                ok   = 1;
                break;
            end
        end
        if (!ok) check("resp_timeout", 0, 1);
    endtask

    task automatic run_op(input int r, input int a, input int b, output int id, output int prod);
        int gid;
        req_a[r*OPW +: OPW] = a[OPW-1:0];
        req_b[r*OPW +: OPW] = b[OPW-1:0];
        req_valid  = 4'b0001 << r;
        resp_ready = 1'b1;
        wait_accept(gid);
        req_valid = 4'b0000;
        wait_resp(id, prod);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int gid, id, prod;
        int grants[$];
        int exp_order[5];

        rst        = 1'b1;
        req_valid  = 4'b0000;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_product", resp_product, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_req_ready", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single request on requester 0: 3*3, then backpressure.
        req_a[1:0] = 2'd3;
        req_b[1:0] = 2'd3;
        req_valid  = 4'b0001;
        @(negedge clk);
        check("single_req_ready", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk);
        check("single_rv_cycle1", resp_valid, 0);
        @(negedge clk);
        check("single_rv_cycle2", resp_valid, 1);
        check("single_id", resp_id, 0);
        check("single_product", resp_product, 9);
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_resp_valid", resp_valid, 1);
            check("bp_product", resp_product, 9);
            check("bp_id", resp_id, 0);
            check("bp_req_ready", req_ready, 4'b0000);
            check("bp_busy", busy, 1);
        end
        @(posedge clk); #1;
        req_valid  = 4'b0000;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check("post_hs_busy", busy, 0);
        check("post_hs_rv", resp_valid, 0);
        check("post_hs_product_held", resp_product, 9);
        check("post_hs_id_held", resp_id, 0);

        // Reset, then contention with all four requesters valid.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst        = 1'b0;
        req_a      = 8'b10_01_11_10;
        req_b      = 8'b11_10_01_11;
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        @(negedge clk);
        check("first_cycle_req_ready", req_ready, 4'b0001);
        for (int n = 0; n < 5; n++) begin
            wait_accept(gid);
            grants.push_back(gid);
        end
`ifdef MULT_ARB_ROUNDROBIN_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        for (int n = 0; n < 5; n++) check("contention_order", grants[n], exp_order[n]);
        req_valid = 4'b0000;
        for (int i = 0; i < 20 && busy; i++) begin
            @(posedge clk); #1;
        end
        check("drain_idle", busy, 0);

        // Reset while the operation is in CALC: no response may appear.
        req_a[5:4] = 2'd2;
        req_b[5:4] = 2'd3;
        req_valid  = 4'b0100;
        wait_accept(gid);
        check("midop_grant", gid, 2);
        req_valid = 4'b0000;
        rst       = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midop_rv", resp_valid, 0);
        check("midop_busy", busy, 0);
        check("midop_product", resp_product, 0);
        check("midop_id", resp_id, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midop_no_resp", resp_valid, 0);
        end
        @(posedge clk); #1;

        // Exhaustive operands on every requester.
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < 4; a++) begin
                for (int b = 0; b < 4; b++) begin
                    run_op(r, a, b, id, prod);
                    check("exh_product", prod, a * b);
                    check("exh_id", id, r);
                    if (a == 2 && b == 3) check("lit_2x3", prod, 6);
                    if (a == 3 && b == 1) check("lit_3x1", prod, 3);
                    if (a == 0 && b == 3) check("lit_0x3", prod, 0);
                    if (a == 3 && b == 3) check("lit_3x3", prod, 9);
                end
            end
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
